class_vote: RTL and testbench

- Downstream consumer of the linear-classifier datapath.
- Takes the classifier's registered weighted sum and sign flag, aligns them to a sample-valid strobe issued when the image triple enters the classifier, and accumulates frames of FRAME_LEN samples.
- Per frame it reports the positive count, maximum signed weighted sum and majority decision.
- The result is presented through a one-entry valid/ready output buffer with overrun detection.

---
 rtl/class_vote.sv | 161 ++++++++++++++++
 tb/tb_class_vote.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/class_vote.sv
// class_vote: frame-level vote over the linear classifier's output stream.
//
// Aligns the classifier's registered weighted sum and sign flag to the
// sample-valid strobe, which is issued LAT edges earlier when the image
// triple enters the classifier. Samples are accumulated into frames of
// FRAME_LEN. Each frame produces a positive count, the maximum signed sum
// and a strict-majority decision. The result goes out through a one-entry
// valid/ready buffer. If a result is dropped, a sticky overrun flag is set.
//
// Ports:
//   i_clk        rising-edge clock, shared with the classifier
//   i_rst_n      asynchronous active-low reset
//   i_in_valid   image triple presented to the classifier this cycle
//   i_wgt_sum    classifier weighted sum (signed, SUM_W bits)
//   i_pos        classifier sign flag (1 = sum non-negative)
//   i_out_ready  consumer accepts the buffered result
//   o_out_valid  buffer holds an unconsumed frame result
//   o_pos_cnt    number of i_pos=1 samples in the frame
//   o_max_sum    largest signed i_wgt_sum in the frame
//   o_decision   1 iff 2*o_pos_cnt > FRAME_LEN
//   o_overrun    sticky: a completed frame was dropped
//
// Output buffer states:
//   state    | meaning
//   ST_EMPTY | no unconsumed result; o_out_valid = 0
//   ST_FULL  | result held stable until i_out_ready; o_out_valid = 1

module class_vote #(
    parameter int FRAME_LEN = 8,
    parameter int LAT       = 3,
    parameter int SUM_W     = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    input  logic [SUM_W-1:0] i_wgt_sum,
    input  logic             i_pos,
    input  logic             i_out_ready,
    output logic             o_out_valid,
    output logic [7:0]       o_pos_cnt,
    output logic [SUM_W-1:0] o_max_sum,
    output logic             o_decision,
    output logic             o_overrun
);

    localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);
    localparam logic [8:0] FRAME_N  = 9'(FRAME_LEN);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [LAT-1:0]   vd;
    logic [7:0]       cnt;
    logic [7:0]       wpos;
    logic [SUM_W-1:0] wmax;

    logic             consume;
    logic             frame_done;
    logic             new_gt;
    logic [7:0]       acc_pos;
    logic [SUM_W-1:0] acc_max;
    logic             acc_dec;
    logic             load;
    logic             set_ovr;

    // The valid strobe travels alongside the classifier pipeline, so its
    // tail bit marks the cycle in which i_wgt_sum/i_pos belong to a sample.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vd <= '0;
        end else begin
            vd[0] <= i_in_valid;
            for (int i = 1; i < LAT; i++) begin
                vd[i] <= vd[i-1];
            end
        end
    end

    assign consume    = vd[LAT-1];
    assign frame_done = consume && (cnt == LAST_IDX);

    // Frame totals that include the sample arriving this cycle. When cnt is
    // 0, the stale working values from the previous frame are ignored. On a
    // tie, the stored maximum is kept.
    assign new_gt  = $signed(i_wgt_sum) > $signed(wmax);
    assign acc_pos = ((cnt == 8'd0) ? 8'd0 : wpos) + {7'd0, i_pos};
    assign acc_max = ((cnt == 8'd0) || new_gt) ? i_wgt_sum : wmax;
    assign acc_dec = {acc_pos, 1'b0} > FRAME_N;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt  <= '0;
            wpos <= '0;
            wmax <= '0;
        end else if (consume) begin
            cnt  <= frame_done ? 8'd0 : cnt + 8'd1;
            wpos <= acc_pos;
            wmax <= acc_max;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        set_ovr = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (frame_done) begin
                    load    = 1'b1;
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (frame_done) begin
                    // A result consumed on the same edge frees the slot for
                    // the new one. Otherwise, the new result is lost.
                    if (i_out_ready) begin
                        load = 1'b1;
                    end else begin
                        set_ovr = 1'b1;
                    end
                end else if (i_out_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_pos_cnt  <= '0;
            o_max_sum  <= '0;
            o_decision <= 1'b0;
            o_overrun  <= 1'b0;
        end else begin
            if (load) begin
                o_pos_cnt  <= acc_pos;
                o_max_sum  <= acc_max;
                o_decision <= acc_dec;
            end
            if (set_ovr) begin
                o_overrun <= 1'b1;
            end
        end
    end

    assign o_out_valid = (state_q == ST_FULL);

endmodule

// File: tb/tb_class_vote.sv
module tb_class_vote;

    localparam int FL  = 4;
    localparam int LAT = 3;
    localparam int SW  = 16;

    logic          i_clk;
    logic          i_rst_n;
    logic          i_in_valid;
    logic [SW-1:0] i_wgt_sum;
    logic          i_pos;
    logic          i_out_ready;
    logic          o_out_valid;
    logic [7:0]    o_pos_cnt;
    logic [SW-1:0] o_max_sum;
    logic          o_decision;
    logic          o_overrun;

    class_vote #(.FRAME_LEN(FL), .LAT(LAT), .SUM_W(SW)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_in_valid  (i_in_valid),
        .i_wgt_sum   (i_wgt_sum),
        .i_pos       (i_pos),
        .i_out_ready (i_out_ready),
        .o_out_valid (o_out_valid),
        .o_pos_cnt   (o_pos_cnt),
        .o_max_sum   (o_max_sum),
        .o_decision  (o_decision),
        .o_overrun   (o_overrun)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Expected result word: {pos_cnt[7:0], max_sum[15:0], decision}
    logic [24:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int n_pushed = 0;
    int n_popped = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a transfer happens on the edge after a negedge where both
    // valid and ready are high.
    always @(negedge i_clk) begin
        #1;
        if (i_rst_n && o_out_valid && i_out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", {7'd0, o_pos_cnt, o_max_sum, o_decision}, 32'hFFFF_FFFF);
            end else begin
                logic [24:0] e;
                e = exp_q.pop_front();
                n_popped++;
                chk("pos_cnt", {24'd0, o_pos_cnt}, {24'd0, e[24:17]});
                chk("max_sum", {16'd0, o_max_sum}, {16'd0, e[16:1]});
                chk("decision", {31'd0, o_decision}, {31'd0, e[0]});
            end
        end
    end

    task automatic junk();
        i_wgt_sum = 16'($urandom);
        i_pos     = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge i_clk);
            i_in_valid = 1'b0;
            junk();
        end
    endtask

    // Issue FL samples back to back. Each sample's data is driven LAT cycles
    // after its valid strobe. ready_at >= 0 raises i_out_ready at that loop
    // step; step FL-1+LAT precedes the frame-completion edge.
    task automatic send(input logic [63:0] sums, input logic [3:0] poss,
                        input logic [7:0] e_pos, input logic [15:0] e_max,
                        input logic e_dec, input bit push, input int ready_at);
        if (push) begin
            exp_q.push_back({e_pos, e_max, e_dec});
            n_pushed++;
        end
        for (int c = 0; c < FL + LAT; c++) begin
            @(negedge i_clk);
            i_in_valid = (c < FL);
            if (c >= LAT) begin
                i_wgt_sum = sums[(c-LAT)*16 +: 16];
                i_pos     = poss[c-LAT];
            end else begin
                junk();
            end
            if (c == ready_at) i_out_ready = 1'b1;
        end
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_valid"}, {31'd0, o_out_valid}, 32'd0);
        chk({name, "_pos"},   {24'd0, o_pos_cnt},   32'd0);
        chk({name, "_max"},   {16'd0, o_max_sum},   32'd0);
        chk({name, "_dec"},   {31'd0, o_decision},  32'd0);
        chk({name, "_ovr"},   {31'd0, o_overrun},   32'd0);
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        repeat (2) @(negedge i_clk);
        #2 i_rst_n = 1'b1;
    endtask

    int vcount;

    initial begin
        i_rst_n     = 1'b0;
        i_in_valid  = 1'b0;
        i_out_ready = 1'b0;
        junk();
        #1;
        chk_zero("reset_hold");
        do_reset();

        // 1: idle after reset with noisy data
        vcount = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge i_clk);
            junk();
            #1;
            if (o_out_valid) vcount++;
        end
        chk("idle_valid_cycles", vcount, 0);
        chk_zero("idle");

        // 2: basic frame; sums listed as {s3,s2,s1,s0}, pos as {p3,p2,p1,p0}
        i_out_ready = 1'b1;
        send({16'h0007, 16'h0040, 16'hFFFD, 16'h0005}, 4'b1101, 8'd3, 16'h0040, 1'b1, 1, -1);
        vcount = 0;
        for (int i = 0; i < 5; i++) begin
            idle(1);
            #1;
            if (i == 0) chk("basic_valid_first", {31'd0, o_out_valid}, 32'd1);
            if (o_out_valid) vcount++;
        end
        chk("basic_pulse_len", vcount, 1);

        // 3: tie -> decision 0; then all-negative including the minimum
        send({16'h0001, 16'h0000, 16'hFF00, 16'hFFF0}, 4'b1100, 8'd2, 16'h0001, 1'b0, 1, -1);
        idle(2);
        send({16'h8001, 16'hFFFF, 16'hFFFE, 16'h8000}, 4'b0000, 8'd0, 16'hFFFF, 1'b0, 1, -1);
        idle(3);

        // 5: slot freed and refilled on the same edge
        do_reset();
        i_out_ready = 1'b0;
        send({16'h8000, 16'hFFF0, 16'hFFFF, 16'h0010}, 4'b0001, 8'd1, 16'h0010, 1'b0, 1, -1);
        idle(2);
        #1;
        chk("sim_full_valid", {31'd0, o_out_valid}, 32'd1);
        chk("sim_full_pos", {24'd0, o_pos_cnt}, 32'd1);
        send({16'hFF00, 16'h0300, 16'h0200, 16'h0100}, 4'b0111, 8'd3, 16'h0300, 1'b1, 1, FL - 1 + LAT);
        idle(1);
        #1;
        chk("sim_valid_stays", {31'd0, o_out_valid}, 32'd1);
        chk("sim_new_max", {16'd0, o_max_sum}, 32'h0300);
        chk("sim_no_overrun", {31'd0, o_overrun}, 32'd0);
        idle(3);

        // 4: backpressure and overrun
        i_out_ready = 1'b0;
        send({16'h0004, 16'h0003, 16'h0002, 16'h0001}, 4'b1111, 8'd4, 16'h0004, 1'b1, 1, -1);
        idle(1);
        #1;
        chk("bp_first_valid", {31'd0, o_out_valid}, 32'd1);
        chk("bp_first_ovr", {31'd0, o_overrun}, 32'd0);
        send({16'h8000, 16'hFFF0, 16'h0010, 16'hFFFF}, 4'b0010, 8'd1, 16'h0010, 1'b0, 0, -1);
        idle(1);
        #1;
        chk("bp_overrun", {31'd0, o_overrun}, 32'd1);
        chk("bp_hold_pos", {24'd0, o_pos_cnt}, 32'd4);
        chk("bp_hold_max", {16'd0, o_max_sum}, 32'h0004);
        chk("bp_hold_valid", {31'd0, o_out_valid}, 32'd1);
        @(negedge i_clk);
        i_out_ready = 1'b1;
        idle(1);
        #1;
        chk("bp_valid_drop", {31'd0, o_out_valid}, 32'd0);
        chk("bp_ovr_sticky", {31'd0, o_overrun}, 32'd1);

        // 6: asynchronous reset with a full buffer, 2 samples consumed, 2 in flight
        do_reset();
        i_out_ready = 1'b0;
        send({16'h0055, 16'h0044, 16'h0033, 16'h0022}, 4'b1111, 8'd4, 16'h0055, 1'b1, 0, -1);
        idle(2);
        #1;
        chk("mid_prefill_valid", {31'd0, o_out_valid}, 32'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge i_clk);
            i_in_valid = (c < 4);
            if (c >= LAT) begin
                i_wgt_sum = 16'h7000;
                i_pos     = 1'b1;
            end else begin
                junk();
            end
        end
        @(posedge i_clk);
        #3 i_rst_n = 1'b0;
        i_in_valid = 1'b0;
        #1;
        chk_zero("mid_async");
        #13 i_rst_n = 1'b1;
        i_out_ready = 1'b1;
        idle(6);
        #1;
        chk("mid_no_stale", {31'd0, o_out_valid}, 32'd0);
        send({16'h0001, 16'hFFFF, 16'h0003, 16'h0002}, 4'b1011, 8'd3, 16'h0003, 1'b1, 1, -1);
        idle(4);

        chk("queue_drained", exp_q.size(), 0);
        chk("results_seen", n_popped, n_pushed);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
